// File: rtl/blake2_digest_tx.sv
// blake2_digest_tx: captures a finished BLAKE2b digest and streams it out
// one byte per valid/ready handshake, byte 0 first.
module blake2_digest_tx #(
  parameter int DIGEST_BYTES = 64,
  parameter int CNT_W        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [8*DIGEST_BYTES-1:0] hash_i,
  input  logic [CNT_W-1:0]          hash_nn_i,
  input  logic                      hash_valid_i,
  output logic                      hash_ready_o,
  input  logic                      abort_i,
  output logic [7:0]                data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic                      last_o,
  output logic                      busy_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DIGEST_BYTES);
  logic [0:0]                r_state;
  logic [8*DIGEST_BYTES-1:0] r_sr;
  logic [CNT_W-1:0]          r_cnt;
  logic                      w_send;
  logic                      w_cap;
  logic                      w_hs;
  logic [CNT_W-1:0]          w_len;
  assign w_send       = r_state == SEND;
  assign hash_ready_o = !w_send && ena;
  assign data_valid_o = w_send;
  assign busy_o       = w_send;
  assign last_o       = w_send && r_cnt == CNT_W'(1);
  assign data_o       = w_send ? r_sr[7:0] : 8'h00;
  assign w_cap        = hash_valid_i && hash_ready_o;
  assign w_hs         = w_send && data_ready_i && ena;
  // Zero or oversized requests fall back to the full digest length.
  assign w_len        = (hash_nn_i == '0 || hash_nn_i > MAX_LEN) ? MAX_LEN : hash_nn_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else if (ena) begin
      if (abort_i) begin
        r_state <= IDLE;
        r_sr    <= '0;
        r_cnt   <= '0;
      end else if (w_cap) begin
        r_state <= SEND;
        r_sr    <= hash_i;
        r_cnt   <= w_len;
      end else if (w_hs) begin
        r_state <= last_o ? IDLE : SEND;
        r_sr    <= last_o ? '0 : r_sr >> 8;
        r_cnt   <= r_cnt - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_blake2_digest_tx.sv
// tb_blake2_digest_tx: directed sequence with random digests, checked against
// a byte-array reference of the expected output stream.
module tb_blake2_digest_tx;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         ena = 1;
  logic [511:0] hash_i = '0;
  logic [6:0]   hash_nn_i = '0;
  logic         hash_valid_i = 0;
  logic         hash_ready_o;
  logic         abort_i = 0;
  logic [7:0]   data_o;
  logic         data_valid_o;
  logic         data_ready_i = 0;
  logic         last_o;
  logic         busy_o;
  logic [7:0]   exp_b [64];
  int           n_pass = 0;
  int           n_chk = 0;

  blake2_digest_tx #(.DIGEST_BYTES(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .hash_i(hash_i), .hash_nn_i(hash_nn_i),
    .hash_valid_i(hash_valid_i), .hash_ready_o(hash_ready_o), .abort_i(abort_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .last_o(last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic int elen(input int nn);
    return (nn == 0 || nn > 64) ? 64 : nn;
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < 64; k++) begin
      exp_b[k] = mode == 0 ? 8'(k) : mode == 1 ? 8'($urandom) : 8'haa;
      hash_i[8*k +: 8] = exp_b[k];
    end
  endtask

  task automatic send(input int nn);
    int n = 0;
    while (!hash_ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", 32'(hash_ready_o), 1);
    hash_nn_i = 7'(nn);
    hash_valid_i = 1;
    @(posedge clk); #1;
    hash_valid_i = 0;
  endtask

  task automatic recv(input int len, input int stop, input int bp, input bit inj, input bit gate);
    int  k = 0;
    int  cyc = 0;
    int  g = 0;
    bit  rdy;
    while (k < stop && cyc < 1000) begin
      rdy = bp == 0 ? 1'b1 : bp == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      ena = !(gate && k == 20 && g < 5);
      if (!ena) begin
        g++;
        rdy = 1;
      end
      data_ready_i = rdy;
      if (inj && k == 3) begin
        hash_valid_i = 1;
        hash_i = {64{8'haa}};
      end
      chk("valid", 32'(data_valid_o), 1);
      chk("data", 32'(data_o), 32'(exp_b[k]));
      chk("last", 32'(last_o), 32'(k == len - 1));
      chk("busy", 32'(busy_o), 1);
      @(posedge clk); #1;
      cyc++;
      if (rdy && ena) k++;
    end
    data_ready_i = 0;
    ena = 1;
    chk("count", k, stop);
    if (bp == 0 && !gate) chk("cycles", cyc, stop);
    if (stop == len) begin
      chk("end_valid", 32'(data_valid_o), 0);
      chk("end_last", 32'(last_o), 0);
      chk("end_busy", 32'(busy_o), 0);
      chk("end_data", 32'(data_o), 0);
      chk("end_ready", 32'(hash_ready_o), 1);
    end
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(data_valid_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_last", 32'(last_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(hash_ready_o), 1);
    fill(0); send(64); recv(64, 64, 0, 0, 0);
    send(32); recv(32, 32, 1, 0, 0);
    fill(1); send(0); recv(elen(0), elen(0), 2, 0, 0);
    fill(1); send(100); recv(elen(100), elen(100), 0, 0, 0);
    fill(0); send(1); recv(1, 1, 0, 0, 0);
    // A second digest offered mid-stream must wait for the first to drain.
    fill(1); send(64); recv(64, 64, 0, 1, 0);
    for (int k = 0; k < 64; k++) exp_b[k] = 8'haa;
    @(posedge clk); #1;
    hash_valid_i = 0;
    recv(64, 64, 0, 0, 0);
    fill(1); send(64); recv(64, 64, 0, 0, 1);
    fill(1); send(64); recv(64, 11, 0, 0, 0);
    abort_i = 1;
    @(posedge clk); #1;
    abort_i = 0;
    chk("abort_valid", 32'(data_valid_o), 0);
    chk("abort_ready", 32'(hash_ready_o), 1);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_data", 32'(data_o), 0);
    fill(0); send(64); recv(64, 6, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(data_valid_o), 0);
    chk("arst_data", 32'(data_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(hash_ready_o), 1);
    chk("post_rst_valid", 32'(data_valid_o), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/blake2_digest_tx.md
Name: blake2_digest_tx

Overview:
- Transmit side of the chip's byte-wide pin interface.
- Captures a finished BLAKE2b digest from the hash core and streams it to the external host one byte per handshake over the 8-bit output pins.
- Uses a valid/ready strobe pair: valid goes out on a bidirectional pin, ready comes in on a dedicated input pin.
- It is the counterpart of the input-side byte loader and sits between the compression core and uo_out/uio_out in tt_um_essen.

Parameters:
- DIGEST_BYTES, 64: maximum digest length in bytes; legal range 1..64. Sets the shift register width to 8*DIGEST_BYTES.
- CNT_W, 7: width of the remaining-byte counter; must satisfy 2**CNT_W > DIGEST_BYTES.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ena  input  1  design enable; when low, all state is frozen.
- hash_i  input  8*DIGEST_BYTES  digest from the core; byte k is hash_i[8k+7:8k].
- hash_nn_i  input  CNT_W  requested output length in bytes.
- hash_valid_i  input  1  core offers a digest.
- hash_ready_o  output  1  block can accept a digest.
- abort_i  input  1  synchronous abort of the current transfer.
- data_o  output  8  current output byte, driven to uo_out.
- data_valid_o  output  1  data_o holds a valid byte.
- data_ready_i  input  1  host accepts a byte this cycle.
- last_o  output  1  data_o is the final byte of the digest.
- busy_o  output  1  a transfer is in progress.

Behaviour:
- Clock and reset: single clock domain. rst_n low asynchronously clears all state.
- Reset values:
  - state = IDLE; shift register = 0; counter = 0.
  - data_o = 8'h00; data_valid_o = 0; last_o = 0; busy_o = 0.
  - hash_ready_o = 1 after the first enabled cycle; it is combinational from state, so it reads 1 in IDLE whenever ena = 1.
- FSM has two states: IDLE and SEND.
- IDLE:
  - hash_ready_o = ena.
  - When hash_valid_i & hash_ready_o, capture hash_i into the shift register and load the counter with the effective length L, then go to SEND.
  - L = DIGEST_BYTES if hash_nn_i == 0 or hash_nn_i > DIGEST_BYTES; otherwise L = hash_nn_i.
- SEND:
  - hash_ready_o = 0; busy_o = 1; data_valid_o = 1.
  - data_o = shift register bits [7:0], so bytes go out little-endian (byte 0 first).
  - last_o = (counter == 1).
  - On a handshake (data_valid_o & data_ready_i & ena): shift right by 8 with zero fill and decrement the counter.
  - If the handshake occurs while last_o = 1, go to IDLE. On that same edge, clear data_valid_o, last_o, busy_o and data_o to 0.
  - data_o and last_o must remain stable while data_valid_o = 1 and data_ready_i = 0.
- Latency:
  - A digest captured at edge N gives data_valid_o = 1 with byte 0 in the cycle after edge N.
  - With data_ready_i held at 1, byte k is presented in cycle N+1+k.
  - hash_ready_o returns to 1 in the cycle after the final handshake edge.
  - Back-to-back digests therefore cost one idle cycle between them.
- Boundary and special cases:
  - hash_valid_i during SEND is ignored and nothing is captured; the core must hold its digest until hash_ready_o.
  - L = 1: the first byte has last_o = 1, and the FSM returns to IDLE after one handshake.
  - abort_i = 1 with ena = 1 in any state forces IDLE and clears the shift register, counter and outputs on that edge. Abort takes priority over a simultaneous handshake or capture.
  - ena = 0: no capture, shift, count or state change, and outputs hold their values. data_valid_o stays asserted, but a handshake is not counted.
  - rst_n asserted mid-transfer: outputs clear immediately without waiting for a clock edge. The remaining bytes are discarded and no partial completion is signalled.
  - The counter never wraps; it is only decremented in SEND while it is at least 1.

Test Plan:
- Full digest: reset, then hash_i = bytes 0x00..0x3F (byte k = k), hash_nn_i = 64, data_ready_i = 1.
  - data_o sequence is 0x00..0x3F over 64 consecutive cycles.
  - last_o is high only on 0x3F.
  - hash_ready_o returns to 1 one cycle later.
- Short digest with backpressure: hash_nn_i = 32, data_ready_i toggling 1,0,0,1,...
  - Exactly 32 bytes are accepted, 0x00..0x1F.
  - data_o and last_o stay stable during stalls.
  - last_o is high on 0x1F.
- Clamp and zero length: hash_nn_i = 0 gives 64 bytes; hash_nn_i = 100 gives 64 bytes; hash_nn_i = 1 gives a single byte 0x00 with last_o = 1.
- Ignore while busy: assert hash_valid_i with a different digest (all 0xAA) during SEND.
  - The original stream is unaffected; no 0xAA appears.
  - The 0xAA digest is accepted only after hash_ready_o rises.
- Abort and reset mid-stream:
  - abort_i pulse after byte 10 gives data_valid_o = 0 the next cycle and hash_ready_o = 1.
  - rst_n low after byte 5 clears data_valid_o and data_o asynchronously, before the next clk edge.
- Enable gating: ena = 0 for 5 cycles mid-stream with data_ready_i = 1 → no bytes are consumed and the byte sequence resumes unchanged when ena = 1.
